icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage and the memory controller. It answers fetch lookups in one cycle on a hit. On a miss it issues a single 4-byte fetch to the memory controller's instruction port, writes the returned word into the line, and forwards it to fetch. A pipeline clear cancels the outstanding response but never aborts a memory transaction already requested.

---
 rtl/icache.sv | 121 ++++++++++++
 tb/tb_icache.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache: hits answer in 1 cycle, misses fetch one word via mem_need/mem_ins_ready.
// rdy_in low freezes every register; a pipeline clear drops the pending response but lets an issued fill finish.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic        mem_need,
  output logic [31:0] mem_addr,
  input  logic        mem_ins_ready,
  input  logic [31:0] mem_ins
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem [LINES];
  logic [31:0]             data_mem [LINES];
  logic [31:2]             req_pc_q, req_pc_d;
  logic                    discard_q, discard_d;
  logic                    if_valid_d;
  logic [31:0]             if_ins_d;
  logic                    mem_need_d;
  logic [31:0]             mem_addr_d;
  logic                    fill;

  logic [INDEX_BITS-1:0]   idx;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic                    hit;
  logic                    accept;
  logic                    unused_pc_bits;

  assign idx            = if_pc[INDEX_BITS+1:2];
  assign fill_idx       = req_pc_q[INDEX_BITS+1:2];
  assign hit            = valid_q[idx] && (tag_mem[idx] == if_pc[31:INDEX_BITS+2]);
  // A live if_valid means fetch has not yet consumed the previous word.
  assign accept         = (state_q == IDLE) && if_req && !if_valid && !clear_in;
  assign unused_pc_bits = ^if_pc[1:0];

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    if_valid_d = 1'b0;
    if_ins_d   = if_ins;
    mem_need_d = mem_need;
    mem_addr_d = mem_addr;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            if_valid_d = 1'b1;
            if_ins_d   = data_mem[idx];
          end else begin
            req_pc_d   = if_pc[31:2];
            mem_need_d = 1'b1;
            mem_addr_d = {if_pc[31:2], 2'b00};
            discard_d  = 1'b0;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (clear_in) discard_d = 1'b1;
        if (mem_ins_ready) begin
          fill       = 1'b1;
          mem_need_d = 1'b0;
          mem_addr_d = 32'd0;
          state_d    = IDLE;
          if (!discard_q && !clear_in) begin
            if_valid_d = 1'b1;
            if_ins_d   = mem_ins;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      req_pc_q  <= '0;
      discard_q <= 1'b0;
      if_valid  <= 1'b0;
      if_ins    <= 32'd0;
      mem_need  <= 1'b0;
      mem_addr  <= 32'd0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
      if_valid  <= if_valid_d;
      if_ins    <= if_ins_d;
      mem_need  <= mem_need_d;
      mem_addr  <= mem_addr_d;
      if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Fill is written even when the response is discarded; the word is still correct.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill) begin
      tag_mem[fill_idx]  <= req_pc_q[31:INDEX_BITS+2];
      data_mem[fill_idx] <= mem_ins;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: stimulus pushes expected fetch responses, a negedge monitor pops and compares them.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic        if_valid;
  logic [31:0] if_ins;
  logic        mem_need;
  logic [31:0] mem_addr;
  logic        mem_ins_ready = 1'b0;
  logic [31:0] mem_ins = 32'd0;

  typedef struct {
    logic [31:0] ins;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  icache #(.INDEX_BITS(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .if_req(if_req), .if_pc(if_pc), .if_valid(if_valid), .if_ins(if_ins),
    .mem_need(mem_need), .mem_addr(mem_addr),
    .mem_ins_ready(mem_ins_ready), .mem_ins(mem_ins)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every if_valid pulse must match the oldest expected response, in the expected cycle.
  always @(negedge clk_in) begin
    if (if_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_if_valid: got ins %h at cycle %0d, required no response", if_ins, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (if_ins !== e.ins || cyc != e.cyc) begin
          errors++;
          $display("FAIL if_response: got ins %h at cycle %0d, required ins %h at cycle %0d",
                   if_ins, cyc, e.ins, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] ins);
    exp_t e;
    e.ins = ins;
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic do_hit(input logic [31:0] pc, input logic [31:0] ins);
    if_req = 1'b1;
    if_pc  = pc;
    push(ins);
    tick();
    if_req = 1'b0;
    check("hit_no_mem_need", {31'd0, mem_need}, 32'd0);
    tick();
  endtask

  task automatic start_miss(input logic [31:0] pc);
    if_req = 1'b1;
    if_pc  = pc;
    tick();
    check("miss_mem_need", {31'd0, mem_need}, 32'd1);
    check("miss_mem_addr", mem_addr, {pc[31:2], 2'b00});
  endtask

  task automatic respond(input logic [31:0] ins, input bit expect_resp);
    mem_ins_ready = 1'b1;
    mem_ins       = ins;
    if (expect_resp) push(ins);
    tick();
    mem_ins_ready = 1'b0;
    if_req        = 1'b0;
    check("fill_mem_need_low", {31'd0, mem_need}, 32'd0);
    check("fill_mem_addr_zero", mem_addr, 32'd0);
    tick();
  endtask

  task automatic miss_fill(input logic [31:0] pc, input logic [31:0] ins);
    start_miss(pc);
    repeat (3) tick();
    check("wait_mem_need_held", {31'd0, mem_need}, 32'd1);
    respond(ins, 1'b1);
  endtask

  initial begin
    tick();
    tick();
    rst_in = 1'b0;
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_ins", if_ins, 32'd0);
    check("rst_mem_need", {31'd0, mem_need}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    tick();

    // Cold miss, hit, conflict eviction on index 0, separate index, ignored low pc bits.
    miss_fill(32'h0000_0100, 32'h0000_0013);
    do_hit(32'h0000_0100, 32'h0000_0013);
    miss_fill(32'h0000_0200, 32'hAAAA_0001);
    do_hit(32'h0000_0200, 32'hAAAA_0001);
    miss_fill(32'h0000_0100, 32'h0000_0013);
    miss_fill(32'h0000_0104, 32'h0000_0055);
    do_hit(32'h0000_0107, 32'h0000_0055);
    do_hit(32'h0000_0100, 32'h0000_0013);

    // Flush two cycles into a miss: fill completes silently, then the line hits.
    start_miss(32'h0000_0300);
    tick();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    if_req   = 1'b0;
    tick();
    check("flush_mem_need_held", {31'd0, mem_need}, 32'd1);
    respond(32'h0BAD_0300, 1'b0);
    do_hit(32'h0000_0300, 32'h0BAD_0300);

    // Clear coincident with mem_ins_ready: line filled, no response.
    start_miss(32'h0000_0400);
    tick();
    clear_in = 1'b1;
    respond(32'h0000_4444, 1'b0);
    clear_in = 1'b0;
    do_hit(32'h0000_0400, 32'h0000_4444);

    // Clear with a request in IDLE: neither a hit nor a miss is taken.
    clear_in = 1'b1;
    if_req   = 1'b1;
    if_pc    = 32'h0000_0400;
    tick();
    if_pc    = 32'h0000_0500;
    tick();
    check("clear_req_no_miss", {31'd0, mem_need}, 32'd0);
    clear_in = 1'b0;
    if_req   = 1'b0;
    tick();

    // Stall: rdy_in low with a ready pulse present must not be sampled.
    start_miss(32'h0000_0600);
    rdy_in        = 1'b0;
    mem_ins_ready = 1'b1;
    mem_ins       = 32'hDEAD_DEAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_mem_need", {31'd0, mem_need}, 32'd1);
    end
    check("stall_mem_addr", mem_addr, 32'h0000_0600);
    rdy_in        = 1'b1;
    mem_ins_ready = 1'b0;
    tick();
    check("post_stall_mem_need", {31'd0, mem_need}, 32'd1);
    respond(32'h0000_6666, 1'b1);
    do_hit(32'h0000_0600, 32'h0000_6666);

    // Asynchronous reset in the middle of WAIT.
    start_miss(32'h0000_0700);
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_mem_need", {31'd0, mem_need}, 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_if_valid", {31'd0, if_valid}, 32'd0);
    rst_in = 1'b0;
    if_req = 1'b0;
    tick();
    tick();
    miss_fill(32'h0000_0100, 32'h0000_0013);
    do_hit(32'h0000_0100, 32'h0000_0013);

    repeat (4) tick();
    check("responses_outstanding", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
